// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the datapath load/store port.
// It accepts one request at a time and holds it for a fixed number of wait
// states. A store is committed to the internal array and a load returns the
// array word. Each request ends with a one-cycle ack. Addresses at or above
// DEPTH are acknowledged with err=1 and never touch the array.
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 17,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_CMP;
  endfunction

  assign mem_rd = mem[lat_addr[IDX_W-1:0]];

  // Select the store that commits on the edge entering RESP: the live request
  // fields when there are no wait states, otherwise the latched copies.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    wr_en   = 1'b0;
    wr_idx  = lat_addr[IDX_W-1:0];
    wr_data = lat_wdata;
    if (state == S_IDLE) begin
      if (WAIT_INIT == 4'd0 && req && we && in_range(addr)) begin
        wr_en   = 1'b1;
        wr_idx  = addr[IDX_W-1:0];
        wr_data = wdata;
      end
    end else if (state == S_WAIT) begin
      if (cnt <= 4'd1 && lat_we && in_range(lat_addr)) begin
        wr_en = 1'b1;
      end
    end
  end

  // Data array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive rst and stay undefined until written.
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          busy  <= 1'b0;
          if (req) begin
            lat_addr  <= addr;
            lat_we    <= we;
            lat_wdata <= wdata;
            cnt       <= WAIT_INIT;
            busy      <= 1'b1;
            state     <= (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          ack  <= 1'b1;
          busy <= 1'b1;
          if (!in_range(lat_addr)) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            err   <= 1'b0;
            rdata <= lat_we ? lat_wdata : mem_rd;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the datapath's load/store port.
- The datapath is the initiator: it raises a request with address, write enable and write data. This block accepts the request, inserts a fixed number of wait states, commits the write or returns the read data, and pulses an acknowledge.
- Sits between the datapath and the data RAM array. It holds the array internally and gives the datapath a realistic multi-cycle memory to stall against.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 17, number of implemented words; addresses >= DEPTH are out of range
- WAIT_CYCLES, 2, wait states between acceptance and acknowledge (0..15)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req  input  1  request valid from datapath; held high until ack seen
- we  input  1  1 = store, 0 = load; qualified by req
- addr  input  ADDR_W  word address; qualified by req
- wdata  input  DATA_W  store data; qualified by req and we
- rdata  output  DATA_W  load data; valid only while ack=1
- ack  output  1  one-cycle completion pulse
- err  output  1  out-of-range flag; valid only while ack=1
- busy  output  1  high from acceptance through the ack cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE, wait counter = 0.
  - rdata=0, ack=0, err=0, busy=0; latched request registers cleared.
  - RAM contents are not reset and are undefined until written.
- FSM states are IDLE, WAIT and RESP; all outputs are registered.
- IDLE:
  - If req=1 at a rising edge, latch addr, we and wdata, set busy=1 and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - If req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next state is RESP.
  - req, addr and wdata are ignored here; only the latched copies are used.
- RESP (one cycle):
  - ack=1 and busy=1.
  - Load: rdata = mem[latched addr].
  - Store: mem[latched addr] <= latched wdata is committed on the edge entering RESP; rdata = latched wdata.
  - The next state is always IDLE, where ack=0, busy=0 and rdata is cleared to 0.
- Latency: request sampled at edge N gives ack high in the cycle after edge N+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles of busy before the ack cycle ends. With WAIT_CYCLES=0, ack appears one cycle after acceptance.
- Handshake rules:
  - The initiator must hold req and its fields stable until it samples ack=1, then drop req or present a new request.
  - req still high in the first IDLE cycle after RESP is treated as a new request. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- Out of range (latched addr >= DEPTH):
  - No RAM access and no write.
  - Acknowledge on the same schedule with err=1 and rdata=0.
- Read-after-write: a load issued after a store's ack returns the new data.
- Reset mid-operation: a store whose RESP edge has not occurred is discarded. The FSM returns to IDLE immediately and ack is never asserted for that request.
- Arithmetic: the counter is 4 bits. The address compare is unsigned and ADDR_W wide.

Test Plan:
- Reset check: hold rst=0 for 10 ns with clk at a 4 ns period -> ack=0, busy=0, err=0, rdata=0. After release, IDLE with busy=0 until req.
- Store then load, WAIT_CYCLES=2:
  - Store addr=5, wdata=8'hA5 -> ack high exactly 3 cycles after the accept edge, err=0.
  - Then load addr=5 -> rdata=8'hA5 in the ack cycle, and rdata=0 the following cycle.
- Zero wait (WAIT_CYCLES=0): load addr=16 after storing 8'h3C there -> ack one cycle after acceptance, rdata=8'h3C, busy high for exactly 2 cycles.
- Out of range (DEPTH=17):
  - Store addr=17, wdata=8'hFF -> ack with err=1, rdata=0.
  - A subsequent load of addr=0 returns its prior value, proving no aliasing write.
- Back-to-back: hold req=1 with stores to addr 1, 2, 3 (data 8'h11, 8'h22, 8'h33), changing fields right after each ack -> three ack pulses spaced WAIT_CYCLES+2 cycles apart; loads return 8'h11, 8'h22, 8'h33.
- Reset mid-WAIT:
  - Store addr=7, wdata=8'h77, then pulse rst=0 during WAIT -> no ack, busy drops immediately.
  - A later load of addr=7 returns the value written before the aborted store, not 8'h77.
